// File: rtl/apb_rm_pkg.sv
// Shared definitions for the APB completer model: FSM states, wait modes, LFSR taps.
package apb_rm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [1:0] WM_ZERO  = 2'd0;
  localparam logic [1:0] WM_FIXED = 2'd1;
  localparam logic [1:0] WM_RAND  = 2'd2;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/apb_rm_lfsr.sv
// 16-bit Fibonacci LFSR, advances only when adv is high; exposes the low OUT_W bits.
module apb_rm_lfsr
  import apb_rm_pkg::*;
#(
  parameter int          OUT_W = 4,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter logic [15:0] TAPS  = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [OUT_W-1:0] rnd
);

  logic [15:0] lfsr_q;

  // shift left, feedback is the xor of the tapped bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    lfsr_q <= SEED;
    else if (adv) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & TAPS)};
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/apb_resp_model_mc.sv
// APB4 completer model: NUM_SEL banks with byte strobes, programmable wait states,
// decode/injected errors. All outputs registered.
module apb_resp_model_mc
  import apb_rm_pkg::*;
#(
  parameter int                NUM_SEL    = 2,
  parameter int                ADDR_W     = 20,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 16,
  parameter int                WAIT_W     = 4,
  parameter logic [DATA_W-1:0] RESET_DATA = 16'hABCD,
  parameter logic [DATA_W-1:0] ERR_DATA   = 16'hDEAD,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SEL-1:0]    psel,
  input  logic                  penable,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  input  logic [1:0]            wait_mode,
  input  logic [WAIT_W-1:0]     wait_cnt,
  input  logic                  err_inject,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int NB = DATA_W / 8;
  localparam int BO = (NB > 1) ? $clog2(NB) : 0;       // byte-offset bits, ignored
  localparam int IW = $clog2(DEPTH);                   // word index bits
  localparam int CW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

  logic [NUM_SEL-1:0][DEPTH-1:0][DATA_W-1:0] bank_q;

  state_t              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                err_q, err_d;
  logic                wr_q, wr_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                pready_d, pslverr_d;
  logic [DATA_W-1:0]   prdata_d;

  logic                sel_any, sel_multi, range_err, setup_err;
  logic [CW-1:0]       sel_idx;
  logic [WAIT_W:0]     mod_den;
  logic [WAIT_W-1:0]   setup_w;
  logic [WAIT_W-1:0]   rnd;
  logic                lfsr_adv;
  logic                commit;

  apb_rm_lfsr #(
    .OUT_W (WAIT_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (lfsr_adv),
    .rnd   (rnd)
  );

  // setup-phase decode: channel, error sources, wait count for the chosen mode
  always_comb begin
    sel_any   = |psel;
    sel_multi = |(psel & (psel - NUM_SEL'(1)));
    sel_idx   = '0;
    for (int i = 0; i < NUM_SEL; i++)
      if (psel[i]) sel_idx = CW'(i);
    range_err = |(paddr >> (BO + IW));
    setup_err = sel_multi | range_err | err_inject;
    mod_den   = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};
    case (wait_mode)
      WM_FIXED: setup_w = wait_cnt;
      WM_RAND:  setup_w = WAIT_W'({1'b0, rnd} % mod_den);
      default:  setup_w = '0;   // WM_ZERO and the unused encoding
    endcase
  end

  // next-state and next-output logic; outputs are registered from the *_d values
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    err_d    = err_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    lfsr_adv = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_any && !penable) begin
          lfsr_adv = 1'b1;
          ch_d     = sel_idx;
          idx_d    = paddr[BO +: IW];
          err_d    = setup_err;
          wr_d     = pwrite;
          cnt_d    = setup_w;
          if (setup_w == '0) begin
            pready_d = 1'b1;
            state_d  = COMPLETE;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        // requester abandoned the transfer: drop it silently
        if (!(sel_any && penable)) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_W'(1)) begin
          pready_d = 1'b1;
          state_d  = COMPLETE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      COMPLETE: begin
        commit  = wr_q & ~err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // read data is sampled from the bank on the edge that enters COMPLETE
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (pready_d) begin
      prdata_d  = err_d ? ERR_DATA : bank_q[ch_d][idx_d];
      pslverr_d = err_d;
    end
  end

  // FSM, transfer context and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      pready  <= pready_d;
      prdata  <= prdata_d;
      pslverr <= pslverr_d;
    end
  end

  // register banks: byte-strobed write at the end of COMPLETE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= {(NUM_SEL * DEPTH){RESET_DATA}};
    end else if (commit) begin
      for (int b = 0; b < NB; b++)
        if (pstrb[b]) bank_q[ch_q][idx_q][b*8 +: 8] <= pwdata[b*8 +: 8];
    end
  end

endmodule

// File: doc/apb_resp_model_mc.md
Name: apb_resp_model_mc

Overview:
- Parametrised, synthesizable APB4 completer model used as the peripheral-side responder in SPI-slave and crypto-accelerator benches and FPGA smoke builds.
- Serves NUM_SEL one-hot select channels, each backed by its own DEPTH-word register bank with byte strobes.
- Wait states are programmable: none, fixed, or LFSR pseudo-random.
- pslverr is raised for decode errors (out-of-range address, multi-hot select) and for forced error injection.

Parameters:
- NUM_SEL, 2, number of psel channels / register banks
- ADDR_W, 20, paddr width
- DATA_W, 16, pwdata/prdata width; must be a multiple of 8
- DEPTH, 16, words per bank; power of two
- WAIT_W, 4, width of wait-state counter
- RESET_DATA, 16'hABCD, reset value of every bank word
- ERR_DATA, 16'hDEAD, prdata returned on an errored read
- LFSR_SEED, 16'hACE1, nonzero seed of 16-bit Fibonacci LFSR (taps 16,14,13,11)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- psel  in  NUM_SEL  one-hot channel select
- penable  in  1  APB access phase
- paddr  in  ADDR_W  byte address
- pwrite  in  1  1 = write
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  byte write strobes
- wait_mode  in  2  0 = zero-wait, 1 = fixed, 2 = random, 3 = treated as 0
- wait_cnt  in  WAIT_W  fixed wait count; also the max for random mode
- err_inject  in  1  force pslverr on the next transfer that sees its setup phase
- prdata  out  DATA_W  read data, valid only while pready=1
- pready  out  1  transfer completion
- pslverr  out  1  error, valid only while pready=1

Behaviour:
- Reset:
  - All outputs are registered; on reset, prdata=0, pready=0, pslverr=0.
  - FSM returns to IDLE and the LFSR loads LFSR_SEED.
  - Every bank word is set to RESET_DATA.
  - Reset asserted mid-transfer aborts the transfer; no write occurs.
- FSM states and transitions:
  - IDLE: on any psel bit set with penable=0, go to SETUP actions. The setup cycle is the IDLE cycle where this is sampled.
  - On that setup cycle, latch into registers: the channel index, error flag, and wait count W.
  - W per mode: mode 0 gives W=0; mode 1 gives W=wait_cnt; mode 2 gives W=lfsr[WAIT_W-1:0] mod (wait_cnt+1).
  - The LFSR advances once per setup cycle only.
  - If W==0, set pready=1 for the next cycle (COMPLETE); otherwise go to WAIT with counter=W.
  - WAIT: decrement each cycle while psel&penable. When counter reaches 1, register pready=1 and go to COMPLETE.
- Latency: pready is high in access cycle number W+1, counting the first penable cycle as 1.
- COMPLETE:
  - pready=1 for exactly one cycle, with prdata and pslverr.
  - The write commits at the clock edge ending this cycle.
  - Next state is IDLE; pready deasserts the following cycle.
  - Back-to-back transfers are supported: a new setup in the cycle after COMPLETE is accepted.
- Error conditions (evaluated at setup):
  - psel not one-hot.
  - Word index paddr[ADDR_W-1:log2(DATA_W/8)] >= DEPTH.
  - err_inject=1.
- On error: no write takes effect, prdata=ERR_DATA, pslverr=1. The wait sequence is still honoured.
- Address decode: byte-offset bits of paddr are ignored; there is no unaligned error.
- Writes: only bytes with pstrb[i]=1 update. pstrb=0 is a legal no-op with no error.
- Reads: return the bank word captured at COMPLETE, i.e. read-after-write to the same word in the next transfer returns the new data.
- Protocol violation: if psel or penable drops before COMPLETE, return to IDLE, pready stays 0, no write occurs. Changes to wait_mode, wait_cnt or err_inject mid-transfer have no effect.
- prdata is 0 outside COMPLETE.

Decomposition:
- Package apb_rm_pkg holds:
  - FSM state encoding (IDLE, WAIT, COMPLETE).
  - Wait-mode constants WM_ZERO, WM_FIXED, WM_RAND.
  - The default LFSR tap mask.
- One sub-module, apb_rm_lfsr: 16-bit LFSR with seed parameter and advance enable.
- Banks stay in the top level as a NUM_SEL x DEPTH register array.

Test Plan:
- Reset, then mode 0, read ch0 addr 0x4 → pready in 1st access cycle, prdata=16'hABCD, pslverr=0.
- Mode 1, wait_cnt=3: write ch1 addr 0x6 data 16'h1234 pstrb=2'b01, then read it back → each pready in 4th access cycle; read returns 16'hAB34.
- psel=2'b11, or paddr=0x20 with DEPTH=16 → pslverr=1, prdata=16'hDEAD, bank unchanged on subsequent read.
- Mode 2, wait_cnt=7, 8 reads after reset → wait counts match the reference LFSR sequence from 16'hACE1, all ≤7; repeat after reset gives the identical sequence.
- Assert reset during WAIT of a write of 16'h5555 → pready/pslverr 0 immediately, word reads back 16'hABCD.
- Drop penable after 1 cycle of a 3-wait write → no pready, no write; a following zero-wait transfer completes normally.
